// File: rtl/block_mem_backend_if.sv
// rtl/block_mem_backend_if.sv - cache-side request/response bus for the block memory backend
interface block_mem_backend_if #(
  parameter int BLOCK_WIDTH = 128
);
  logic                   req_valid;
  logic                   req_write;
  logic [31:0]            req_addr;
  logic [BLOCK_WIDTH-1:0] req_data;
  logic                   resp_ready;
  logic [BLOCK_WIDTH-1:0] resp_data;
  logic                   busy;

  modport master (
    output req_valid, req_write, req_addr, req_data,
    input  resp_ready, resp_data, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data,
    output resp_ready, resp_data, busy
  );
endinterface

// File: rtl/block_mem_backend.sv
// rtl/block_mem_backend.sv - fixed-latency block memory serving cache fills and write-backs
module block_mem_backend #(
  parameter int BLOCK_WIDTH = 128,
  parameter int DEPTH_LOG2  = 10,
  parameter int LATENCY     = 4
) (
  input  logic                clk,
  input  logic                rst,
  block_mem_backend_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_RELOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t                  r_state, w_state_nxt;
  logic [3:0]              r_count, w_count_nxt;
  logic                    r_lat_write, w_lat_write_nxt;
  logic [DEPTH_LOG2-1:0]   r_lat_idx, w_lat_idx_nxt;
  logic [BLOCK_WIDTH-1:0]  r_lat_data, w_lat_data_nxt;
  logic                    r_resp_ready, w_resp_ready_nxt;
  logic [BLOCK_WIDTH-1:0]  r_resp_data, w_resp_data_nxt;
  logic                    r_busy, w_busy_nxt;

  // Storage is deliberately excluded from reset so preloaded contents survive it.
  logic [BLOCK_WIDTH-1:0]  r_mem [0:DEPTH-1];

  logic                    w_do_op;
  logic                    w_op_write;
  logic [DEPTH_LOG2-1:0]   w_op_idx;
  logic [BLOCK_WIDTH-1:0]  w_op_data;
  logic [DEPTH_LOG2-1:0]   w_req_idx;
  logic                    w_unused_addr_bits;

  assign w_req_idx          = bus.req_addr[DEPTH_LOG2+3:4];
  assign w_unused_addr_bits = ^{bus.req_addr[31:DEPTH_LOG2+4], bus.req_addr[3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= 4'd0;
      r_lat_write  <= 1'b0;
      r_lat_idx    <= '0;
      r_lat_data   <= '0;
      r_resp_ready <= 1'b0;
      r_resp_data  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_lat_write  <= w_lat_write_nxt;
      r_lat_idx    <= w_lat_idx_nxt;
      r_lat_data   <= w_lat_data_nxt;
      r_resp_ready <= w_resp_ready_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_lat_write_nxt  = r_lat_write;
    w_lat_idx_nxt    = r_lat_idx;
    w_lat_data_nxt   = r_lat_data;
    w_busy_nxt       = r_busy;
    w_resp_ready_nxt = 1'b0;
    w_do_op          = 1'b0;
    w_op_write       = r_lat_write;
    w_op_idx         = r_lat_idx;
    w_op_data        = r_lat_data;

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_lat_write_nxt = bus.req_write;
          w_lat_idx_nxt   = w_req_idx;
          w_lat_data_nxt  = bus.req_data;
          w_busy_nxt      = 1'b1;
          // Single-cycle latency completes on the acceptance edge from the live inputs.
          if (LATENCY == 1) begin
            w_state_nxt      = S_DONE;
            w_do_op          = 1'b1;
            w_op_write       = bus.req_write;
            w_op_idx         = w_req_idx;
            w_op_data        = bus.req_data;
            w_resp_ready_nxt = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_count_nxt = LAT_RELOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_count == 4'd0) begin
          w_state_nxt      = S_DONE;
          w_do_op          = 1'b1;
          w_resp_ready_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    w_resp_data_nxt = r_resp_data;
    if (w_do_op) begin
      w_resp_data_nxt = w_op_write ? w_op_data : r_mem[w_op_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_do_op && w_op_write) begin
      r_mem[w_op_idx] <= w_op_data;
    end
  end

  assign bus.resp_ready = r_resp_ready;
  assign bus.resp_data  = r_resp_data;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_block_mem_backend.sv
// tb/tb_block_mem_backend.sv - self-checking bench for block_mem_backend against a block-array model
module tb_block_mem_backend;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [127:0] ref_mem [0:1023];

  block_mem_backend_if #(.BLOCK_WIDTH(128)) bus ();
  block_mem_backend_if #(.BLOCK_WIDTH(128)) bus1 ();

  block_mem_backend #(.BLOCK_WIDTH(128), .DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  block_mem_backend #(.BLOCK_WIDTH(128), .DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction on the LATENCY=LAT instance; optionally drives conflicting requests while busy.
  task automatic xact(input logic w, input logic [31:0] a, input logic [127:0] d,
                      input bit mess, input logic [31:0] mess_addr);
    logic [127:0] exp;
    int idx;
    int n;
    idx = int'(a[13:4]);
    if (w) begin
      ref_mem[idx] = d;
      exp = d;
    end else begin
      exp = ref_mem[idx];
    end
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_data  = d;
    tick;
    chk("busy_after_accept", bus.busy, 1'b1);
    bus.req_valid = mess;
    bus.req_write = 1'b1;
    bus.req_addr  = mess_addr;
    bus.req_data  = rnd128();
    n = 0;
    while (bus.resp_ready !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("resp_latency", n, LAT - 1);
    chk("resp_data", bus.resp_data, exp);
    bus.req_valid = 1'b0;
    tick;
    chk("resp_ready_pulse_end", bus.resp_ready, 1'b0);
    chk("busy_cleared", bus.busy, 1'b0);
    chk("resp_data_hold", bus.resp_data, exp);
  endtask

  initial begin
    logic [127:0] v;
    logic [127:0] old32;
    logic [127:0] pre_l1;
    int pulses;
    int first_p;
    int second_p;
    int errs;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus1.req_valid = 1'b0;
    bus1.req_write = 1'b0;
    bus1.req_addr  = '0;
    bus1.req_data  = '0;

    for (int i = 0; i < 1024; i++) begin
      v = rnd128();
      dut.r_mem[i] = v;
      ref_mem[i]   = v;
    end
    v = 128'h0123456789abcdef0123456789abcdef;
    dut.r_mem[0] = v;
    ref_mem[0]   = v;
    pre_l1 = rnd128();
    u_l1.r_mem[5] = pre_l1;

    tick;
    tick;
    rst = 1'b0;
    chk("reset_resp_ready", bus.resp_ready, 1'b0);
    chk("reset_resp_data", bus.resp_data, '0);
    chk("reset_busy", bus.busy, 1'b0);

    xact(1'b0, 32'd8, rnd128(), 1'b0, 32'd0);
    chk("preload_read", bus.resp_data, 128'h0123456789abcdef0123456789abcdef);

    xact(1'b1, 32'd256, 128'haabbccdd_eeff0011_22334455_66778899, 1'b0, 32'd0);
    xact(1'b0, 32'd256, rnd128(), 1'b0, 32'd0);
    chk("write_read_data", bus.resp_data, 128'haabbccdd_eeff0011_22334455_66778899);
    chk("array16", dut.r_mem[16], 128'haabbccdd_eeff0011_22334455_66778899);

    v = rnd128();
    xact(1'b1, 32'h10, v, 1'b0, 32'd0);
    xact(1'b0, 32'h10 + 32'd16384, rnd128(), 1'b0, 32'd0);
    chk("alias_read", bus.resp_data, v);

    xact(1'b0, 32'd0, rnd128(), 1'b1, 32'd512);
    chk("ignore_busy_array32", dut.r_mem[32], ref_mem[32]);

    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'd0;
    pulses = 0;
    first_p = -1;
    second_p = -1;
    for (int i = 0; i < 14; i++) begin
      tick;
      if (bus.resp_ready === 1'b1) begin
        pulses++;
        if (first_p < 0) first_p = i;
        else if (second_p < 0) begin
          second_p = i;
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.req_valid = 1'b0;
    chk("held_valid_pulses", pulses, 2);
    chk("held_valid_first", first_p, LAT - 1);
    chk("held_valid_spacing", second_p - first_p, LAT + 1);
    chk("held_valid_data", bus.resp_data, ref_mem[0]);

    old32 = ref_mem[32];
    pulses = 0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'd512;
    bus.req_data  = rnd128();
    tick;
    bus.req_valid = 1'b0;
    if (bus.resp_ready === 1'b1) pulses++;
    tick;
    if (bus.resp_ready === 1'b1) pulses++;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_mid_resp_ready", bus.resp_ready, 1'b0);
    chk("rst_mid_resp_data", bus.resp_data, '0);
    chk("rst_mid_busy", bus.busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.resp_ready === 1'b1) pulses++;
    end
    chk("rst_mid_no_pulse", pulses, 0);
    chk("rst_mid_array32", dut.r_mem[32], old32);

    bus1.req_valid = 1'b1;
    bus1.req_write = 1'b0;
    bus1.req_addr  = 32'h50;
    tick;
    bus1.req_valid = 1'b0;
    chk("l1_read_ready", bus1.resp_ready, 1'b1);
    chk("l1_read_data", bus1.resp_data, pre_l1);
    chk("l1_read_busy", bus1.busy, 1'b1);
    tick;
    chk("l1_idle_ready", bus1.resp_ready, 1'b0);
    chk("l1_idle_busy", bus1.busy, 1'b0);
    v = rnd128();
    bus1.req_valid = 1'b1;
    bus1.req_write = 1'b1;
    bus1.req_addr  = 32'h60;
    bus1.req_data  = v;
    tick;
    bus1.req_valid = 1'b0;
    chk("l1_write_ready", bus1.resp_ready, 1'b1);
    chk("l1_write_array", u_l1.r_mem[6], v);
    tick;
    bus1.req_valid = 1'b1;
    bus1.req_write = 1'b0;
    bus1.req_addr  = 32'h60;
    tick;
    bus1.req_valid = 1'b0;
    chk("l1_write_read", bus1.resp_data, v);
    tick;

    for (int t = 0; t < 30; t++) begin
      xact(1'($urandom_range(0, 1)), $urandom, rnd128(), 1'($urandom_range(0, 1)), $urandom);
    end

    errs = 0;
    for (int i = 0; i < 1024; i++) begin
      if (dut.r_mem[i] !== ref_mem[i]) errs++;
    end
    chk("final_array_mismatches", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/block_mem_backend.md
Name: block_mem_backend

Overview:
- Next-level block memory sitting directly downstream of the data cache. It serves the cache's block-granular miss fills and dirty write-backs.
- Accepts one 128-bit block request at a time over a valid/ready handshake.
- Models a fixed access latency with a counter-driven FSM and returns a one-cycle response pulse.
- Storage is a flat block array. The bench preloads and inspects it hierarchically, so it is never cleared by reset.

Parameters:
BLOCK_WIDTH, 128, bits per block; block = 16 bytes, so offset width = 4
DEPTH_LOG2, 10, log2 of block count (1024 blocks = 16 KiB)
LATENCY, 4, cycles from request acceptance to response; legal range 1..15

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present; sampled only in IDLE
req_write  input  1  1 = write block, 0 = read block
req_addr  input  32  byte address; bits [3:0] ignored
req_data  input  BLOCK_WIDTH  write block data
resp_ready  output  1  one-cycle pulse: request complete
resp_data  output  BLOCK_WIDTH  read data; for writes, echoes the written block
busy  output  1  high from acceptance until the cycle after the resp_ready pulse

Behaviour:
- Reset (rst=1 at an edge) forces:
  - state=IDLE, counter=0, resp_ready=0, resp_data=0, busy=0.
  - Latched request registers are cleared.
  - Block array is untouched.
- Index = req_addr[DEPTH_LOG2+3:4]. Upper address bits are ignored, so addresses alias modulo 2^(DEPTH_LOG2+4) bytes.
- FSM states are IDLE, WAIT, DONE.
- IDLE:
  - With req_valid=1 at edge k, latch write/index/data and assert busy.
  - If LATENCY=1, go to DONE; otherwise go to WAIT with counter=LATENCY-2.
  - With req_valid=0, stay in IDLE and keep outputs unchanged, except resp_ready=0.
- WAIT:
  - If counter=0, go to DONE; else decrement counter.
  - req_* inputs are ignored (no queuing, no re-latch).
- DONE, entered at edge k+LATENCY-1:
  - At that same edge, a write updates array[index] with the latched data and sets resp_data to that data.
  - At that same edge, a read sets resp_data to array[index], already including any earlier completed write.
  - resp_ready=1 for exactly the one cycle following edge k+LATENCY-1. Response is visible LATENCY cycles after acceptance.
  - Next edge: return to IDLE, resp_ready=0, busy=0.
  - req_valid is not sampled in DONE.
- Back-to-back requests:
  - A new request is accepted no earlier than the first IDLE edge after DONE.
  - The cache must drop req_valid in the cycle it observes resp_ready. If req_valid is still high in IDLE, it is accepted as a new request.
- resp_data holds its value until the next completion or reset.
- Simultaneous rst and request: reset wins and the request is dropped.
- Reset mid-operation (WAIT or DONE):
  - The pending write is discarded and the array is not modified, unless the write edge already occurred.
  - No resp_ready is produced.
- No partial-block writes. Byte/half masking is the cache's job.

Test Plan:
- Read latency: preload array[0]=128'h0123...cdef, LATENCY=4, req_valid=1 read addr=8 at edge 0.
  - resp_ready high only in cycle after edge 3, resp_data=preload; busy low after edge 4.
- Write then read: write addr=256 data=128'haabbccdd_... and drop req_valid on resp_ready, then read addr=256.
  - Read returns written data; array[16] equals it.
- Aliasing: write addr=0x10 data=A, then read addr=0x10+16384.
  - Read returns A.
- Ignore during busy: accept read addr=0, then change req_addr=512/req_write=1 during WAIT.
  - Response reflects addr 0 read; array[32] unchanged.
- Held valid: keep req_valid=1 continuously, read addr=0.
  - Second acceptance on the IDLE edge right after DONE; exactly two resp_ready pulses separated by LATENCY+1 cycles.
- Reset mid-write: accept write addr=512 data=B, assert rst during WAIT.
  - resp_ready never pulses, array[32] keeps old value, outputs all 0 after reset.
- LATENCY=1: read accepted at edge 0.
  - resp_ready in cycle after edge 0, back to IDLE at edge 1.
